// File: rtl/dac_frame_ctrl.sv
// dac_frame_ctrl: sequences transfers to an external DAC through an SPI master.
// After a power-up delay a clear frame is issued, then samples arriving on a
// valid/ready handshake are packed into 32-bit command frames. Each frame is
// started with a one-cycle strobe and its completion is tracked through the
// SPI slave-select line, with a timeout on the start of the transfer.
module dac_frame_ctrl #(
    parameter int unsigned bits    = 32,
    parameter int unsigned dw      = 12,
    parameter logic [3:0]  cmd     = 4'b0011,
    parameter int unsigned pwr_dly = 100,
    parameter int unsigned tmo     = 16,
    parameter int unsigned gap     = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [dw-1:0]   sample,
    input  logic [3:0]      addr,
    input  logic            sample_valid,
    output logic            sample_ready,
    input  logic            clr_req,
    input  logic            spi_ss,
    output logic            spi_en,
    output logic            spi_clr_ctrl,
    output logic [bits-1:0] spi_data,
    output logic            done,
    output logic            err
);

    // Counter must reach the largest of the three delays without wrapping.
    localparam int unsigned MAX_A = (pwr_dly > tmo) ? pwr_dly : tmo;
    localparam int unsigned MAX_B = (MAX_A > gap) ? MAX_A : gap;
    localparam int unsigned CW    = $clog2(MAX_B) + 1;

    localparam logic [CW-1:0] PWR_LAST = CW'(pwr_dly);
    localparam logic [CW-1:0] TMO_LAST = CW'(tmo - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(gap - 1);

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_CLR  = 3'd1,
        ST_IDLE = 3'd2,
        ST_SEND = 3'd3,
        ST_WLO  = 3'd4,
        ST_WHI  = 3'd5,
        ST_GAP  = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [bits-1:0] data_q, data_d;
    logic            spi_en_q;
    logic            clr_ctrl_q;
    logic            done_q;
    logic            err_q;

    logic            accept_s;
    logic            err_set_s;
    logic            done_set_s;
    logic [15:0]     field_s;
    logic [bits-1:0] frame_s;

    // Ready is gated by clr_req in the same cycle so that a pending clear
    // request can never coexist with an advertised (and then ignored) ready.
    assign sample_ready = (state_q == ST_IDLE) & ~clr_req;

    assign spi_en       = spi_en_q;
    assign spi_clr_ctrl = clr_ctrl_q;
    assign spi_data     = data_q;
    assign done         = done_q;
    assign err          = err_q;

    // Command frame: zero byte, command nibble, channel, left-justified sample.
    always_comb begin
        field_s            = 16'h0000;
        field_s[15 -: dw]  = sample;
        frame_s            = {8'h00, cmd, addr, field_s};
    end

    // Next-state decode, event flags, frame register and counter next values.
    always_comb begin
        state_d    = state_q;
        accept_s   = 1'b0;
        err_set_s  = 1'b0;
        done_set_s = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == PWR_LAST) begin
                    state_d = ST_CLR;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_CLR: begin
                state_d = ST_WLO;
            end
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLR;
                end else if (sample_valid) begin
                    accept_s = 1'b1;
                    state_d  = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                state_d = ST_WLO;
            end
            ST_WLO: begin
                if (!spi_ss) begin
                    state_d = ST_WHI;
                end else if (cnt_q == TMO_LAST) begin
                    err_set_s = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_WLO;
                end
            end
            ST_WHI: begin
                if (spi_ss) begin
                    done_set_s = 1'b1;
                    state_d    = ST_GAP;
                end else begin
                    state_d = ST_WHI;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // Frame only changes when a new transfer is being launched.
        if (accept_s) begin
            data_d = frame_s;
        end else if ((state_d == ST_CLR) && (state_q != ST_CLR)) begin
            data_d = '0;
        end else begin
            data_d = data_q;
        end

        // Counter restarts on every state entry and only runs in timed states.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == ST_INIT) || (state_q == ST_WLO) || (state_q == ST_GAP)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, counter and registered output decodes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            data_q     <= '0;
            spi_en_q   <= 1'b0;
            clr_ctrl_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            spi_en_q   <= (state_d == ST_CLR) || (state_d == ST_SEND);
            clr_ctrl_q <= (state_d == ST_CLR);
            done_q     <= done_set_s;
            err_q      <= err_q | err_set_s;
        end
    end

endmodule

// File: tb/tb_dac_frame_ctrl.sv
// Self-checking bench for dac_frame_ctrl: a scoreboard queue holds expected
// frames, pushed when a sample or clear is issued and popped on each spi_en.
// A simple SPI slave-select model answers each strobe.
module tb_dac_frame_ctrl;

    localparam int PWR_DLY = 100;
    localparam int TMO     = 16;
    localparam int GAP     = 4;

    logic        clk;
    logic        rst;
    logic [11:0] sample;
    logic [3:0]  addr;
    logic        sample_valid;
    logic        sample_ready;
    logic        clr_req;
    logic        spi_ss;
    logic        spi_en;
    logic        spi_clr_ctrl;
    logic [31:0] spi_data;
    logic        done;
    logic        err;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          en_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    bit          have_done = 1'b0;
    bit          prev_done = 1'b0;
    bit          ss_dead = 1'b0;
    logic [31:0] held_data = 32'h0;
    logic [32:0] sb[$];

    dac_frame_ctrl #(
        .bits(32), .dw(12), .cmd(4'b0011),
        .pwr_dly(PWR_DLY), .tmo(TMO), .gap(GAP)
    ) dut (
        .clk(clk), .rst(rst), .sample(sample), .addr(addr),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .clr_req(clr_req), .spi_ss(spi_ss), .spi_en(spi_en),
        .spi_clr_ctrl(spi_clr_ctrl), .spi_data(spi_data),
        .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_frame(input logic [3:0] a, input logic [11:0] s);
        return {8'h00, 4'b0011, a, s, 4'h0};
    endfunction

    // SPI slave-select model: falls some cycles after a strobe, low for a while.
    initial begin
        spi_ss = 1'b1;
        forever begin
            @(negedge clk);
            if (spi_en && !ss_dead) begin
                repeat (spi_clr_ctrl ? 8 : 2) @(negedge clk);
                spi_ss = 1'b0;
                repeat (12) @(negedge clk);
                spi_ss = 1'b1;
            end
        end
    end

    // Output monitor: scoreboard pops, frame hold, pulse widths, inter-frame gap.
    initial begin
        logic [32:0] exp;
        forever begin
            @(negedge clk);
            check_eq("clr_without_en", spi_clr_ctrl & ~spi_en, 1'b0);
            if (spi_en) begin
                en_cnt++;
                held_data = spi_data;
                if (sb.size() == 0) begin
                    check_eq("sb_unexpected_frame", {spi_clr_ctrl, spi_data}, 33'h0);
                end else begin
                    exp = sb.pop_front();
                    check_eq("frame", {spi_clr_ctrl, spi_data}, exp);
                end
                if (have_done) check_eq("gap_after_done", (cyc - done_cyc) >= (GAP + 1), 1'b1);
            end else if (!rst) begin
                check_eq("frame_hold", spi_data, held_data);
            end
            if (rst) held_data = 32'h0;
            if (done) begin
                check_eq("done_one_cycle", prev_done, 1'b0);
                done_cnt++;
                done_cyc  = cyc;
                have_done = 1'b1;
            end
            prev_done = done;
        end
    end

    task automatic release_and_count(input string tag);
        int k;
        sb.push_back({1'b1, 32'h0});
        rst = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!spi_en && k < 300);
        check_eq(tag, k, PWR_DLY + 1);
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, done, 1'b1);
    endtask

    task automatic ready_after_done(input string tag);
        int k;
        k = 0;
        while (!sample_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, k, GAP);
    endtask

    // Present a sample and hold valid until the DUT takes it; returns at the
    // falling edge after the accepting clock edge. Valid is left asserted.
    task automatic send(input logic [3:0] a, input logic [11:0] s);
        int k;
        k = 0;
        sample       = s;
        addr         = a;
        sample_valid = 1'b1;
        #1;
        while (!sample_ready && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_eq("send_ready", sample_ready, 1'b1);
        sb.push_back({1'b0, exp_frame(a, s)});
        @(negedge clk);
    endtask

    initial begin
        int k;
        int d0;
        int e0;
        rst          = 1'b1;
        sample       = 12'h000;
        addr         = 4'h0;
        sample_valid = 1'b0;
        clr_req      = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_en", spi_en, 1'b0);
        check_eq("rst_clr", spi_clr_ctrl, 1'b0);
        check_eq("rst_data", spi_data, 32'h0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_ready", sample_ready, 1'b0);

        // Power-up delay and clear frame
        release_and_count("por_clear_latency");
        check_eq("por_clear_ctrl", spi_clr_ctrl, 1'b1);
        wait_done("por_done");
        ready_after_done("por_ready_gap");

        // Single sample
        send(4'h0, 12'hABC);
        sample_valid = 1'b0;
        check_eq("single_latency", spi_en, 1'b1);
        check_eq("single_data", spi_data, 32'h0030ABC0);
        check_eq("single_ready_low", sample_ready, 1'b0);
        wait_done("single_done");
        ready_after_done("single_ready_gap");

        // Back-to-back samples with valid held
        e0 = en_cnt;
        send(4'h1, 12'h001);
        send(4'h2, 12'h7FF);
        send(4'h3, 12'hFFF);
        sample_valid = 1'b0;
        wait_done("b2b_done");
        ready_after_done("b2b_ready_gap");
        check_eq("b2b_count", en_cnt - e0, 3);

        // Clear request wins over a simultaneous sample
        clr_req      = 1'b1;
        sample       = 12'h5A5;
        addr         = 4'h7;
        sample_valid = 1'b1;
        sb.push_back({1'b1, 32'h0});
        #1;
        check_eq("clrreq_ready_low", sample_ready, 1'b0);
        @(negedge clk);
        check_eq("clrreq_en", spi_en, 1'b1);
        check_eq("clrreq_ctrl", spi_clr_ctrl, 1'b1);
        check_eq("clrreq_ready_still_low", sample_ready, 1'b0);
        clr_req = 1'b0;
        send(4'h7, 12'h5A5);
        sample_valid = 1'b0;
        wait_done("clrreq_sample_done");
        ready_after_done("clrreq_ready_gap");

        // Timeout: slave-select never falls
        ss_dead = 1'b1;
        send(4'h3, 12'h321);
        sample_valid = 1'b0;
        check_eq("tmo_en", spi_en, 1'b1);
        d0 = done_cnt;
        for (int i = 1; i <= TMO; i++) begin
            @(negedge clk);
            check_eq("tmo_err_early", err, 1'b0);
        end
        @(negedge clk);
        check_eq("tmo_err", err, 1'b1);
        check_eq("tmo_back_idle", sample_ready, 1'b1);
        check_eq("tmo_no_done", done_cnt - d0, 0);
        ss_dead = 1'b0;
        send(4'h1, 12'h456);
        sample_valid = 1'b0;
        wait_done("after_tmo_done");
        check_eq("err_sticky", err, 1'b1);
        ready_after_done("after_tmo_ready_gap");

        // Reset while waiting for slave-select to rise
        send(4'h2, 12'h0F0);
        sample_valid = 1'b0;
        k = 0;
        while (spi_ss && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("whi_ss_low", spi_ss, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_en", spi_en, 1'b0);
        check_eq("midrst_clr", spi_clr_ctrl, 1'b0);
        check_eq("midrst_data", spi_data, 32'h0);
        check_eq("midrst_done", done, 1'b0);
        check_eq("midrst_err", err, 1'b0);
        check_eq("midrst_ready", sample_ready, 1'b0);
        release_and_count("midrst_clear_latency");
        wait_done("midrst_clear_done");
        ready_after_done("midrst_ready_gap");

        check_eq("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dac_frame_ctrl.md
Name: dac_frame_ctrl

Overview:
- Sits directly upstream of the SPI master and sequences every transfer to the external DAC.
- After reset it waits a power-up delay, then issues one clear/shutdown frame: `clr_ctrl` is set, so the SPI master pulses its `clr`.
- It then accepts DAC samples over a valid/ready handshake and formats each one into a 32-bit command frame.
- For each frame it pulses the SPI start strobe and tracks completion through the SPI slave-select line.

Parameters:
- `bits`, 32: SPI frame width; must equal the SPI master's `bits`. Only 32 is supported.
- `dw`, 12: sample width, 1..16. The sample is left-justified in a 16-bit data field.
- `cmd`, 4'b0011: DAC command nibble ("write and update").
- `pwr_dly`, 100: cycles spent in INIT after reset before the clear frame.
- `tmo`, 16: cycles allowed for `spi_ss` to fall after a start strobe. Must be ≥ 10 to cover the SPI clear sequence.
- `gap`, 4: minimum idle cycles between frames (≥ 1).

Ports:
- `clk`, input, 1: system clock; all logic on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `sample`, input, `dw`: DAC code.
- `addr`, input, 4: DAC channel address, qualified with `sample`.
- `sample_valid`, input, 1: upstream has a sample.
- `sample_ready`, output, 1: block can accept a sample this cycle.
- `clr_req`, input, 1: level request to reissue a clear frame.
- `spi_ss`, input, 1: SPI master slave-select. Low means a transfer is in progress.
- `spi_en`, output, 1: one-cycle SPI start strobe.
- `spi_clr_ctrl`, output, 1: qualifies `spi_en` as a clear frame.
- `spi_data`, output, `bits`: frame to the SPI master's `data2trans`.
- `done`, output, 1: one-cycle pulse when a frame completes (`spi_ss` rises).
- `err`, output, 1: sticky timeout flag.

Behaviour:
- Reset values: `sample_ready`=0, `spi_en`=0, `spi_clr_ctrl`=0, `spi_data`=0, `done`=0, `err`=0; state = INIT, counter = 0. Reset mid-transfer abandons the frame without waiting for `spi_ss`.
- Frame format: `{8'h00, cmd, addr, sample, {(16-dw){1'b0}}}`. Registered on acceptance and held stable from the `spi_en` cycle until the frame completes.
- States and transitions:
  - INIT: counts `pwr_dly` cycles, then → CLR.
  - CLR: for one cycle `spi_en`=1, `spi_clr_ctrl`=1, `spi_data`=0; → WLO.
  - IDLE: `sample_ready` = ~`clr_req`.
    - If `clr_req` → CLR. `clr_req` has priority over a simultaneous `sample_valid`; the sample is not accepted.
    - Else if `sample_valid` & `sample_ready` → capture the frame → SEND.
  - SEND: `spi_en`=1 for exactly one cycle, `spi_clr_ctrl`=0; → WLO.
  - WLO: counter cleared on entry.
    - If `spi_ss`==0 → WHI.
    - Else if the counter reaches `tmo`-1 → `err` set, → IDLE without a `done` pulse.
  - WHI: no timeout. When `spi_ss`==1 → `done`=1 for one cycle, → GAP.
  - GAP: holds for `gap` cycles, then → IDLE.
- Handshake:
  - `sample_ready` is asserted only in IDLE.
  - At most one sample is accepted per frame; there is no buffering. Upstream holds `sample_valid` until accepted.
- Outputs:
  - `spi_en` and `spi_clr_ctrl` are registered decodes of the state and never assert outside CLR/SEND.
  - `err` clears only on `rst`.
- Latency:
  - Acceptance edge → `spi_en` high: next cycle.
  - Release of reset → CLR strobe: `pwr_dly`+1 cycles.
- Counter: ⌈log2(max(`pwr_dly`,`tmo`,`gap`))⌉+1 bits. It resets to 0 on every state entry and never wraps within a state.

Test Plan:
- Reset release, `spi_ss` model with the clear sequence → `spi_en`=`spi_clr_ctrl`=1 exactly at cycle 101, `spi_data`=0. `done` pulses when the model's `ss` rises. `sample_ready` rises `gap` cycles later.
- `sample`=12'hABC, `addr`=4'h0, valid for 1 cycle in IDLE → `spi_en` next cycle with `spi_data`=32'h0030ABC0. `sample_ready`=0 until `done`+4 cycles.
- `sample_valid` held high with 3 back-to-back samples (12'h001, 12'h7FF, 12'hFFF) → exactly 3 `spi_en` pulses, frames in order, ≥ 4 idle cycles between `done` and the next `spi_en`.
- `spi_ss` held at 1 after SEND → `err`=1 at the 16th WLO cycle, no `done`, return to IDLE; `err` stays 1 across later successful frames.
- `clr_req` and `sample_valid` both high in IDLE → CLR frame first (`spi_clr_ctrl`=1, `sample_ready`=0). The sample is accepted only after `clr_req` drops.
- `rst` asserted while in WHI → next cycle all outputs at reset values, state INIT; a fresh clear frame is issued 101 cycles after release.
